// File: rtl/spi_cfg_seq_if.sv
// spi_cfg_seq_if: start request, table lookup and SPI-writer handshake bundle
// shared between spi_cfg_seq (slave) and its environment (master).
interface spi_cfg_seq_if;
    logic        start;
    logic        ORDY;
    logic [3:0]  tbl_addr;
    logic [15:0] tbl_data;
    logic [15:0] regdata;
    logic        GO;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] csum;

    modport slave (
        input  start, ORDY, tbl_data,
        output tbl_addr, regdata, GO, busy, done, err, csum
    );

    modport master (
        output start, ORDY, tbl_data,
        input  tbl_addr, regdata, GO, busy, done, err, csum
    );
endinterface

// File: rtl/spi_cfg_seq.sv
// spi_cfg_seq: streams NWORDS table words to an SPI writer over a GO/ORDY handshake.
// Optional XOR checksum of sent words is built when SPI_CFG_SEQ_CHECKSUM_EN is defined.
module spi_cfg_seq #(
    parameter int NWORDS  = 8,
    parameter int GAP     = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic         CLK,
    input  logic         reset,
    spi_cfg_seq_if.slave bus
);
    localparam logic [3:0]  LAST_IDX = 4'(NWORDS - 1);
    localparam logic [7:0]  GAP_LAST = 8'(GAP - 1);
    localparam logic [15:0] TMO      = 16'(TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_WAIT_RDY  = 4'd2,
        S_PULSE     = 4'd3,
        S_WAIT_ACK  = 4'd4,
        S_WAIT_DONE = 4'd5,
        S_GAP       = 4'd6,
        S_FIN       = 4'd7,
        S_ERR       = 4'd8
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] regdata_q, regdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic [7:0]  gcnt_q, gcnt_d;
    logic        go_s;
    logic        busy_s;

    // State register
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_FETCH;
                else           state_d = S_IDLE;
            end
            S_FETCH:    state_d = S_WAIT_RDY;
            S_WAIT_RDY: begin
                if (bus.ORDY) state_d = S_PULSE;
                else          state_d = S_WAIT_RDY;
            end
            S_PULSE:    state_d = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (!bus.ORDY)          state_d = S_WAIT_DONE;
                else if (tcnt_q == TMO) state_d = S_ERR;
                else                    state_d = S_WAIT_ACK;
            end
            S_WAIT_DONE: begin
                if (bus.ORDY) begin
                    if (idx_q == LAST_IDX) state_d = S_FIN;
                    else                   state_d = S_GAP;
                end else if (tcnt_q == TMO) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_GAP: begin
                if (gcnt_q == GAP_LAST) state_d = S_FETCH;
                else                    state_d = S_GAP;
            end
            S_FIN:   state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: GO and busy come straight from the registered state
    always_comb begin
        go_s   = 1'b0;
        busy_s = 1'b1;
        case (state_q)
            S_IDLE:  busy_s = 1'b0;
            S_PULSE: go_s   = 1'b1;
            default: begin
                go_s   = 1'b0;
                busy_s = 1'b1;
            end
        endcase
    end

    // Datapath next-state: index, latched word, sticky flags and counters
    always_comb begin
        idx_d     = idx_q;
        regdata_d = regdata_q;
        done_d    = done_q;
        err_d     = err_q;
        tcnt_d    = tcnt_q;
        gcnt_d    = gcnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    idx_d  = 4'd0;
                    done_d = 1'b0;
                    err_d  = 1'b0;
                end else begin
                    idx_d  = idx_q;
                end
            end
            S_FETCH: regdata_d = bus.tbl_data;
            S_PULSE: tcnt_d    = 16'd0;
            S_WAIT_ACK: begin
                if (!bus.ORDY)          tcnt_d = 16'd0;
                else if (tcnt_q != TMO) tcnt_d = tcnt_q + 16'd1;
                else                    tcnt_d = tcnt_q;
            end
            S_WAIT_DONE: begin
                if (bus.ORDY)           gcnt_d = 8'd0;
                else if (tcnt_q != TMO) tcnt_d = tcnt_q + 16'd1;
                else                    tcnt_d = tcnt_q;
            end
            S_GAP: begin
                if (gcnt_q == GAP_LAST) idx_d  = idx_q + 4'd1;
                else                    gcnt_d = gcnt_q + 8'd1;
            end
            S_FIN:   done_d = 1'b1;
            S_ERR:   err_d  = 1'b1;
            default: begin
            end
        endcase
    end

    // Datapath registers; index stays on the failing word after a timeout
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            idx_q     <= 4'd0;
            regdata_q <= 16'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            tcnt_q    <= 16'd0;
            gcnt_q    <= 8'd0;
        end else begin
            idx_q     <= idx_d;
            regdata_q <= regdata_d;
            done_q    <= done_d;
            err_q     <= err_d;
            tcnt_q    <= tcnt_d;
            gcnt_q    <= gcnt_d;
        end
    end

`ifdef SPI_CFG_SEQ_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;

    // Checksum accumulates each word as it is handed to the writer
    always_comb begin
        csum_d = csum_q;
        if (state_q == S_IDLE && bus.start) begin
            csum_d = 16'd0;
        end else if (state_q == S_PULSE) begin
            csum_d = csum_q ^ regdata_q;
        end else begin
            csum_d = csum_q;
        end
    end

    // Checksum register
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            csum_q <= 16'd0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign bus.csum = csum_q;
`else
    assign bus.csum = 16'h0000;
`endif

    assign bus.tbl_addr = idx_q;
    assign bus.regdata  = regdata_q;
    assign bus.GO       = go_s;
    assign bus.busy     = busy_s;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_spi_cfg_seq.sv
// tb_spi_cfg_seq: vector table, random runs against a queue-based word model,
// plus hand sequences for handshake timeout and mid-run reset.
module tb_spi_cfg_seq;
    localparam int NW    = 3;
    localparam int GAP_A = 4;
    localparam int TMO_B = 20;

    logic        CLK;
    logic        reset;
    logic [15:0] tbl_a [0:15];
    int          total;
    int          bad;

    spi_cfg_seq_if ifa ();
    spi_cfg_seq_if ifb ();

    assign ifa.tbl_data = tbl_a[ifa.tbl_addr];
    assign ifb.tbl_data = tbl_a[ifb.tbl_addr];

    spi_cfg_seq #(.NWORDS(NW), .GAP(GAP_A), .TIMEOUT(1023)) dut_a (
        .CLK   (CLK),
        .reset (reset),
        .bus   (ifa.slave)
    );

    spi_cfg_seq #(.NWORDS(NW), .GAP(GAP_A), .TIMEOUT(TMO_B)) dut_b (
        .CLK   (CLK),
        .reset (reset),
        .bus   (ifb.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
        int          drop;
        int          hold;
        int          pre_low;
        int          poke;
        logic [15:0] exp_csum;
    } vec_t;

    vec_t vecs [4];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One full run on dut_a with a writer that drops ORDY 'drop' cycles after GO
    // and raises it 'hold' cycles later; checks every GO against the word queue.
    task automatic run_a(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                         input int drop, input int hold, input int pre_low, input int poke,
                         input logic [15:0] exp_csum);
        logic [15:0] expq [$];
        logic [15:0] x;
        logic [15:0] csum_exp;
        int cyc, go_n, since, rise_cyc, first_exp;
        bit wr_act;
        tbl_a[0] = w0;
        tbl_a[1] = w1;
        tbl_a[2] = w2;
        expq = {};
        expq.push_back(w0);
        expq.push_back(w1);
        expq.push_back(w2);
`ifdef SPI_CFG_SEQ_CHECKSUM_EN
        csum_exp = exp_csum;
`else
        csum_exp = 16'h0000;
`endif
        first_exp = (pre_low == 0) ? 2 : pre_low + 1;
        ifa.ORDY  = (pre_low == 0);
        ifa.start = 1'b1;
        step();
        ifa.start = 1'b0;
        chk("busy_after_start", 32'(ifa.busy), 32'd1);
        cyc = 0; go_n = 0; since = 0; rise_cyc = 0; wr_act = 1'b0;
        while (ifa.busy && cyc < 2000) begin
            step();
            cyc++;
            if (ifa.GO) begin
                go_n++;
                if (expq.size() == 0) begin
                    chk("extra_go", 32'(go_n), 32'(NW));
                end else begin
                    x = expq.pop_front();
                    chk("go_regdata", 32'(ifa.regdata), 32'(x));
                end
                if (go_n == 1) chk("first_go_lat", 32'(cyc), 32'(first_exp));
                else           chk("rise_to_go", 32'(cyc - rise_cyc), 32'(GAP_A + 3));
                since  = 0;
                wr_act = 1'b1;
            end else if (wr_act) begin
                since++;
                if (since == drop) ifa.ORDY = 1'b0;
                if (since == drop + hold) begin
                    ifa.ORDY = 1'b1;
                    rise_cyc = cyc;
                    wr_act   = 1'b0;
                end
            end else if (pre_low > 0 && go_n == 0 && cyc == pre_low) begin
                ifa.ORDY = 1'b1;
            end
            ifa.start = (cyc == poke);
        end
        ifa.start = 1'b0;
        chk("run_ends", 32'(ifa.busy), 32'd0);
        chk("go_count", 32'(go_n), 32'(NW));
        chk("done", 32'(ifa.done), 32'd1);
        chk("err", 32'(ifa.err), 32'd0);
        chk("final_addr", 32'(ifa.tbl_addr), 32'(NW - 1));
        chk("csum", 32'(ifa.csum), 32'(csum_exp));
        step();
        step();
        chk("regdata_hold_idle", 32'(ifa.regdata), 32'(w2));
        chk("still_idle", 32'(ifa.busy), 32'd0);
    endtask

    initial begin
        int cyc, go_n, since, g2;
        bit wr_act;
        logic [15:0] r0, r1, r2;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 16; i++) tbl_a[i] = 16'h0000;

        vecs[0] = '{16'h1234, 16'h00FF, 16'hA5A5, 2, 34, 0, -1, 16'hB76E};
        vecs[1] = '{16'h0001, 16'h0002, 16'h0004, 1, 1,  0, -1, 16'h0007};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 16'h0000, 3, 5,  0,  5, 16'h0000};
        vecs[3] = '{16'h8000, 16'h0F0F, 16'hF0F0, 1, 10, 6, -1, 16'h7FFF};

        reset     = 1'b1;
        ifa.start = 1'b0;
        ifa.ORDY  = 1'b1;
        ifb.start = 1'b0;
        ifb.ORDY  = 1'b1;
        step();
        step();
        chk("rst_busy", 32'(ifa.busy), 32'd0);
        chk("rst_go", 32'(ifa.GO), 32'd0);
        chk("rst_addr", 32'(ifa.tbl_addr), 32'd0);
        chk("rst_regdata", 32'(ifa.regdata), 32'd0);
        chk("rst_done", 32'(ifa.done), 32'd0);
        chk("rst_err", 32'(ifa.err), 32'd0);
        chk("rst_csum", 32'(ifa.csum), 32'd0);
        chk("rst_b_busy", 32'(ifb.busy), 32'd0);
        reset = 1'b0;
        step();

        for (int v = 0; v < 4; v++) begin
            run_a(vecs[v].w0, vecs[v].w1, vecs[v].w2, vecs[v].drop, vecs[v].hold,
                  vecs[v].pre_low, vecs[v].poke, vecs[v].exp_csum);
        end

        for (int n = 0; n < 8; n++) begin
            r0 = 16'($urandom);
            r1 = 16'($urandom);
            r2 = 16'($urandom);
            run_a(r0, r1, r2, int'($urandom_range(1, 4)), int'($urandom_range(1, 40)),
                  ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : 0,
                  ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 10)) : -1,
                  r0 ^ r1 ^ r2);
        end

        // Timeout: ORDY never drops after the second GO on the short-timeout instance
        tbl_a[0] = 16'h1111;
        tbl_a[1] = 16'h2222;
        tbl_a[2] = 16'h3333;
        ifb.ORDY  = 1'b1;
        ifb.start = 1'b1;
        step();
        ifb.start = 1'b0;
        cyc = 0; go_n = 0; since = 0; g2 = 0; wr_act = 1'b0;
        while (go_n < 2 && cyc < 300) begin
            step();
            cyc++;
            if (ifb.GO) begin
                go_n++;
                if (go_n == 1) begin
                    wr_act = 1'b1;
                    since  = 0;
                end else begin
                    g2 = cyc;
                end
            end else if (wr_act) begin
                since++;
                if (since == 1) ifb.ORDY = 1'b0;
                if (since == 4) begin
                    ifb.ORDY = 1'b1;
                    wr_act   = 1'b0;
                end
            end
        end
        chk("b_two_gos", 32'(go_n), 32'd2);
        while (!ifb.err && cyc < g2 + 200) begin
            step();
            cyc++;
        end
        chk("b_err_lat", 32'(cyc - g2), 32'(TMO_B + 3));
        chk("b_err", 32'(ifb.err), 32'd1);
        chk("b_addr", 32'(ifb.tbl_addr), 32'd1);
        chk("b_done", 32'(ifb.done), 32'd0);
        chk("b_busy", 32'(ifb.busy), 32'd0);
        ifb.start = 1'b1;
        step();
        ifb.start = 1'b0;
        chk("b_err_cleared", 32'(ifb.err), 32'd0);
        chk("b_restart_addr", 32'(ifb.tbl_addr), 32'd0);

        // Asynchronous reset while dut_a waits for the writer to finish word 2
        tbl_a[0] = 16'hC0DE;
        tbl_a[1] = 16'hBEEF;
        tbl_a[2] = 16'h5A5A;
        ifa.ORDY  = 1'b1;
        ifa.start = 1'b1;
        step();
        ifa.start = 1'b0;
        cyc = 0; go_n = 0; since = 0; g2 = -100; wr_act = 1'b0;
        while (cyc < 500 && !(go_n == 2 && cyc == g2 + 10)) begin
            step();
            cyc++;
            if (ifa.GO) begin
                go_n++;
                since  = 0;
                wr_act = 1'b1;
                if (go_n == 2) g2 = cyc;
            end else if (wr_act) begin
                since++;
                if (since == 2) ifa.ORDY = 1'b0;
                if (since == 36) begin
                    ifa.ORDY = 1'b1;
                    wr_act   = 1'b0;
                end
            end
        end
        chk("mid_reach_word2", 32'(go_n), 32'd2);
        chk("mid_busy_before", 32'(ifa.busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(ifa.busy), 32'd0);
        chk("mid_rst_go", 32'(ifa.GO), 32'd0);
        chk("mid_rst_addr", 32'(ifa.tbl_addr), 32'd0);
        chk("mid_rst_regdata", 32'(ifa.regdata), 32'd0);
        chk("mid_rst_done", 32'(ifa.done), 32'd0);
        chk("mid_rst_csum", 32'(ifa.csum), 32'd0);
        step();
        reset    = 1'b0;
        ifa.ORDY = 1'b1;
        step();
        step();
        step();
        chk("mid_wait_idle", 32'(ifa.busy), 32'd0);
        run_a(16'hC0DE, 16'hBEEF, 16'h5A5A, 2, 6, 0, -1, 16'hC0DE ^ 16'hBEEF ^ 16'h5A5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
